// File: rtl/root_disp_pkg.sv
// Shared types, widths, segment patterns and the double-dabble step for the root display driver.
package root_disp_pkg;

  localparam int unsigned ROOT_W     = 7;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SLOT_W     = 2;
  localparam int unsigned BCD_W      = 2 * DIGIT_W;
  localparam int unsigned SHIFT_W    = BCD_W + ROOT_W;
  localparam int unsigned DISP_W     = NUM_DIGITS * DIGIT_W;
  localparam int unsigned MAX_VAL    = 99;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV_W,
    ST_CONV_F,
    ST_COMMIT
  } state_t;

  // Active-low cathode patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // One double-dabble iteration on {tens, ones, binary}: correct nibbles >= 5, then shift left.
  function automatic logic [SHIFT_W-1:0] dd_step(input logic [SHIFT_W-1:0] i_s);
    logic [SHIFT_W-1:0] v;
    v = i_s;
    if (v[10:7] >= 4'd5)  v[10:7]  = v[10:7] + 4'd3;
    if (v[14:11] >= 4'd5) v[14:11] = v[14:11] + 4'd3;
    return {v[SHIFT_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/root_display_driver_if.sv
// Result hand-off from the square-root stage: value plus load strobe, busy back-pressure.
interface root_display_driver_if;
  import root_disp_pkg::*;

  logic              load;
  logic [ROOT_W-1:0] whole;
  logic [ROOT_W-1:0] fracture;
  logic              busy;

  modport master (output load, whole, fracture, input busy);
  modport slave  (input load, whole, fracture, output busy);
endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes blank.
module seg7_decoder
  import root_disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_code,
  output logic [SEG_W-1:0]   o_seg_c
);

  // Table lookup over the ten legal codes.
  always_comb begin
    o_seg_c = SEG_BLANK;
    for (int unsigned k = 0; k < 10; k++) begin
      if (i_code == DIGIT_W'(k)) o_seg_c = SEG_DIGIT[k];
    end
  end

endmodule

// File: rtl/root_display_driver.sv
// Captures a root result, converts it to BCD sequentially and multiplexes "WW.FF" onto 4 digits.
module root_display_driver
  import root_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  root_display_driver_if.slave  bus,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int unsigned CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned ITER_W    = 3;
  localparam int unsigned LAST_ITER = ROOT_W - 1;

  state_t               r_state, w_state_nxt;
  logic                 w_capture, w_commit, w_iter_last, w_converting;
  logic [ITER_W-1:0]    r_iter;
  logic [SHIFT_W-1:0]   r_shift, w_step;
  logic [ROOT_W-1:0]    r_frac_hold;
  logic [BCD_W-1:0]     r_whole_bcd;
  logic                 r_ovf_pend, r_ovf, r_shown, r_busy;
  logic [DISP_W-1:0]    r_digits, w_digits_cur;
  logic                 w_ovf_cur, w_shown_cur;
  logic [CNT_W-1:0]     r_refresh;
  logic [SLOT_W-1:0]    r_slot;
  logic [DIGIT_W-1:0]   w_sel;
  logic [SEG_W-1:0]     w_dec_seg, w_seg_nxt, r_seg;
  logic [NUM_DIGITS-1:0] w_an_nxt, r_an;
  logic                 w_dp_nxt, r_dp;

  assign w_iter_last  = (r_iter == ITER_W'(LAST_ITER));
  assign w_converting = (r_state == ST_CONV_W) || (r_state == ST_CONV_F);
  assign w_step       = dd_step(r_shift);
  assign bus.busy     = r_busy;
  assign seg          = r_seg;
  assign an           = r_an;
  assign dp           = r_dp;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.load) begin
          w_state_nxt = ST_CONV_W;
          w_capture   = 1'b1;
        end
      end
      ST_CONV_W: if (w_iter_last) w_state_nxt = ST_CONV_F;
      ST_CONV_F: if (w_iter_last) w_state_nxt = ST_COMMIT;
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
        w_commit    = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture, double-dabble datapath and atomic digit commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_iter      <= '0;
      r_shift     <= '0;
      r_frac_hold <= '0;
      r_whole_bcd <= '0;
      r_ovf_pend  <= 1'b0;
      r_ovf       <= 1'b0;
      r_shown     <= 1'b0;
      r_digits    <= '0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      if (w_capture) begin
        r_shift     <= {BCD_W'(0), bus.whole};
        r_frac_hold <= bus.fracture;
        r_ovf_pend  <= (bus.whole > ROOT_W'(MAX_VAL)) || (bus.fracture > ROOT_W'(MAX_VAL));
        r_iter      <= '0;
      end else if (w_converting) begin
        r_iter <= w_iter_last ? '0 : r_iter + ITER_W'(1);
        if ((r_state == ST_CONV_W) && w_iter_last) begin
          r_whole_bcd <= w_step[SHIFT_W-1 -: BCD_W];
          r_shift     <= {BCD_W'(0), r_frac_hold};
        end else begin
          r_shift <= w_step;
        end
      end
      if (w_commit) begin
        r_digits <= {r_whole_bcd, r_shift[SHIFT_W-1 -: BCD_W]};
        r_ovf    <= r_ovf_pend;
        r_shown  <= 1'b1;
      end
    end
  end

  // Digit slot timing: advance one anode every REFRESH_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh <= '0;
      r_slot    <= '0;
    end else if (r_refresh == CNT_W'(REFRESH_DIV - 1)) begin
      r_refresh <= '0;
      r_slot    <= r_slot + SLOT_W'(1);
    end else begin
      r_refresh <= r_refresh + CNT_W'(1);
    end
  end

  // Bypass the commit so the output registers pick up new digits on the commit edge itself.
  assign w_digits_cur = w_commit ? {r_whole_bcd, r_shift[SHIFT_W-1 -: BCD_W]} : r_digits;
  assign w_ovf_cur    = w_commit ? r_ovf_pend : r_ovf;
  assign w_shown_cur  = w_commit | r_shown;
  assign w_sel        = w_digits_cur[{r_slot, 2'b00} +: DIGIT_W];

  seg7_decoder u_dec (
    .i_code  (w_sel),
    .o_seg_c (w_dec_seg)
  );

  // Next display pattern for the active slot.
  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = SEG_BLANK;
    w_dp_nxt  = 1'b1;
    if (w_shown_cur) begin
      w_an_nxt = ~(NUM_DIGITS'(1) << r_slot);
      if (w_ovf_cur) begin
        w_seg_nxt = SEG_DASH;
      end else begin
        w_dp_nxt = (r_slot != SLOT_W'(2));
        if (BLANK_LEADING && (r_slot == SLOT_W'(3)) &&
            (w_digits_cur[DISP_W-1 -: DIGIT_W] == DIGIT_W'(0)))
          w_seg_nxt = SEG_BLANK;
        else
          w_seg_nxt = w_dec_seg;
      end
    end
  end

  // Registered anode/cathode/dp outputs, all updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

endmodule
